cla_multiword_seq: RTL and testbench

Sequencer that reuses one `CLA_16_bit_LCU` slice to add (optionally subtract) wide operands one 16-bit word per cycle, least-significant word first. It carries the inter-word carry in a register. It sits between a requester using a valid/ready handshake and the single shared 16-bit CLA datapath, trading latency for area.

---
 rtl/cla_multiword_seq.sv | 181 ++++++++++++++++++
 tb/tb_cla_multiword_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq: multi-word adder that reuses one 16-bit carry-lookahead slice,
// processing one word per cycle, least-significant word first.
// Optional feature macro: CLA_SEQ_SUB_EN adds the op_sub port (A - B mode).

// 16-bit carry-lookahead adder: four 4-bit groups joined by a lookahead carry unit.
module CLA_16_bit_LCU (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out,
    output logic        p,
    output logic        g
);
    logic [15:0] bp, bg, bc;
    logic [3:0]  gp, gg;
    logic [3:0]  gc;

    // Bit/group propagate-generate, group carries, then in-group lookahead carries.
    always_comb begin
        bp = a ^ b;
        bg = a & b;
        for (int i = 0; i < 4; i++) begin
            gp[i] = &bp[4*i +: 4];
            gg[i] = bg[4*i+3] | (bp[4*i+3] & bg[4*i+2])
                  | (bp[4*i+3] & bp[4*i+2] & bg[4*i+1])
                  | (bp[4*i+3] & bp[4*i+2] & bp[4*i+1] & bg[4*i]);
        end
        gc[0] = c_in;
        gc[1] = gg[0] | (gp[0] & c_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & c_in);
        g     = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]);
        p     = &gp;
        c_out = g | (p & c_in);
        for (int i = 0; i < 4; i++) begin
            bc[4*i]   = gc[i];
            bc[4*i+1] = bg[4*i] | (bp[4*i] & gc[i]);
            bc[4*i+2] = bg[4*i+1] | (bp[4*i+1] & bg[4*i]) | (bp[4*i+1] & bp[4*i] & gc[i]);
            bc[4*i+3] = bg[4*i+2] | (bp[4*i+2] & bg[4*i+1])
                      | (bp[4*i+2] & bp[4*i+1] & bg[4*i])
                      | (bp[4*i+2] & bp[4*i+1] & bp[4*i] & gc[i]);
        end
        sum = bp ^ bc;
    end
endmodule

module cla_multiword_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic              c_in,
`ifdef CLA_SEQ_SUB_EN
    input  logic              op_sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic              c_out,
    output logic              ovf,
    output logic              busy
);
    localparam int unsigned W  = 16 * WORDS;
    localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, b_q, sum_q, sum_shift;
    logic            carry_q, c_out_q, ovf_q;
    logic [CW-1:0]   cnt_q;
    logic            last_word;
    logic [15:0]     slice_sum;
    logic            slice_cout;
    logic            lcu_p_unused, lcu_g_unused;
    logic [W-1:0]    b_init;
    logic            carry_init;

    CLA_16_bit_LCU u_slice (
        .a     (a_q[15:0]),
        .b     (b_q[15:0]),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout),
        .p     (lcu_p_unused),
        .g     (lcu_g_unused)
    );

`ifdef CLA_SEQ_SUB_EN
    // Subtract as A + ~B + 1; c_in is ignored in that mode.
    assign b_init     = op_sub ? ~b : b;
    assign carry_init = op_sub ? 1'b1 : c_in;
`else
    assign b_init     = b;
    assign carry_init = c_in;
`endif

    // Each slice result enters at the top so the LS word ends up at the bottom.
    if (WORDS == 1) begin : g_one
        assign sum_shift = slice_sum;
    end else begin : g_many
        assign sum_shift = {slice_sum, sum_q[W-1:16]};
    end

    assign last_word = (cnt_q == CW'(WORDS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun: begin
                if (last_word) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand capture, per-word shifting and final flag latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_init;
                        carry_q <= carry_init;
                        cnt_q   <= '0;
                    end
                end
                StRun: begin
                    sum_q   <= sum_shift;
                    a_q     <= a_q >> 16;
                    b_q     <= b_q >> 16;
                    carry_q <= slice_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_word) begin
                        c_out_q <= slice_cout;
                        ovf_q   <= (a_q[15] == b_q[15]) && (slice_sum[15] != a_q[15]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != StIdle);
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq (WORDS=4): directed cases from the
// design's corner list plus randomized operands against a 65-bit arithmetic model.
module tb_cla_multiword_seq;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0, b = '0;
    logic         c_in = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out, ovf, busy;

    int n_vec = 0;
    int n_err = 0;

    cla_multiword_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef CLA_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, c_out, sum} of the full-width signed/unsigned add.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sub);
        logic [W-1:0] yy;
        logic [W:0]   r;
        logic         ci_eff;
        logic         v;
        yy     = sub ? ~y : y;
        ci_eff = sub ? 1'b1 : ci;
        r      = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci_eff};
        v      = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
        return {v, r};
    endfunction

    // Wait for the result after an accept, check latency and values, then leave it in DONE.
    task automatic collect(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic sub);
        logic [W+1:0] e;
        int lat;
        e   = model(x, y, ci, sub);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, W'(lat), W'(WORDS));
        check({tag, "_sum"}, sum, e[W-1:0]);
        check({tag, "_cout"}, W'(c_out), W'(e[W]));
        check({tag, "_ovf"}, W'(ovf), W'(e[W+1]));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, W'(out_valid), W'(0));
        check({tag, "_ready_rise"}, W'(in_ready), W'(1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sub);
        check({tag, "_ready_pre"}, W'(in_ready), W'(1));
        a = x; b = y; c_in = ci; op_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        collect(tag, x, y, ci, sub);
        release_result(tag);
    endtask

    initial begin
        logic [W-1:0] hs, hx, hy;
        logic         hc, ho;

        #12;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_sum", sum, '0);
        check("rst_flags", W'({c_out, ovf}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("xcarry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        run_op("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
`ifdef CLA_SEQ_SUB_EN
        run_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1);
        run_op("sub_pos", 64'd7, 64'd5, 1'b1, 1'b1);
        run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
`endif

        // Backpressure: result held while new requests are ignored.
        a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; c_in = 1'b1;
        op_sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        collect("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        hs = sum; hc = c_out; ho = ovf;
        hx = 64'hFFFF_0000_FFFF_0000; hy = 64'h0001_0001_0001_0001;
        a = hx; b = hy; c_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_sum", sum, hs);
            check("bp_hold_flags", W'({c_out, ovf, out_valid}), W'({hc, ho, 1'b1}));
            check("bp_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ready_after", W'(in_ready), W'(1));
        @(negedge clk);
        in_valid = 1'b0;
        collect("bp_next", hx, hy, 1'b0, 1'b0);
        release_result("bp_next");

        // Reset in the middle of RUN discards the partial result.
        a = 64'hDEAD_BEEF_0000_1111; b = 64'h1; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", W'(out_valid), W'(0));
        check("mrst_sum", sum, '0);
        check("mrst_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 64'd1, 64'd2, 1'b0, 1'b0);

        // Randomized operands, with word-boundary-heavy patterns mixed in.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] rx, ry;
            logic         rs;
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            if (i % 4 == 1) ry = ~rx;
            if (i % 4 == 2) rx = rx | 64'h7FFF_7FFF_7FFF_7FFF;
            rs = 1'b0;
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            run_op("rand", rx, ry, 1'($urandom_range(0, 1)), rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
